fetch_unit: RTL and testbench

Instruction-fetch initiator for the Rapids core. It drives the MMU instruction port: it issues a word address, honours `wait_instr` and `instr_segv`, and buffers returned words in a 2-entry FIFO. It presents the buffered words to decode over a valid/ready handshake. Decode or branch logic can redirect it to a new PC, which flushes everything in flight.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: drives the MMU instruction port, buffers words in a 2-entry FIFO, hands them to decode.
// Latency: a word accepted from the MMU in cycle N is presented on out_* in cycle N+1; 1 word/cycle sustained.
// Backpressure: a full FIFO (or wait_instr) blocks the push and holds fetch_pc; out_valid/out_ready gate the pop.
// Ports: clk/reset (sync, active-high); MMU side instr_addr/instr/wait_instr/instr_segv;
//        redirect/redirect_pc flush and retarget; decode side out_valid/out_ready/out_instr/out_pc/out_fault.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr,
    input  logic        wait_instr,
    input  logic        instr_segv,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    typedef enum logic {
        FETCH   = 1'b0,
        FAULTED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] ent_instr_q [2];
    logic [31:0] ent_instr_d [2];
    logic [31:0] ent_pc_q    [2];
    logic [31:0] ent_pc_d    [2];
    logic        ent_fault_q [2];
    logic        ent_fault_d [2];

    logic push;
    logic pop;

    assign instr_addr = fetch_pc_q;

    // Outputs come straight from the head registers; no path from instr.
    assign out_valid = (count_q != 2'd0);
    assign out_instr = ent_instr_q[rd_ptr_q];
    assign out_pc    = ent_pc_q[rd_ptr_q];
    assign out_fault = ent_fault_q[rd_ptr_q];

    // Push is judged on the pre-pop count: a full queue never refills in the
    // same cycle it drains, which keeps the FIFO a plain 2-entry register file.
    assign push = (state_q == FETCH) && (count_q != 2'd2) && !wait_instr && !redirect;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        ent_instr_d = ent_instr_q;
        ent_pc_d    = ent_pc_q;
        ent_fault_d = ent_fault_q;

        if (redirect) begin
            // Flush wins over any same-cycle pop; decode squashes that word.
            state_d    = FETCH;
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (push) begin
                ent_pc_d[wr_ptr_q] = fetch_pc_q;
                wr_ptr_d           = ~wr_ptr_q;
                if (instr_segv) begin
                    // Fault marker; fetch_pc stays on the faulting address.
                    ent_instr_d[wr_ptr_q] = 32'd0;
                    ent_fault_d[wr_ptr_q] = 1'b1;
                    state_d               = FAULTED;
                end else begin
                    ent_instr_d[wr_ptr_q] = instr;
                    ent_fault_d[wr_ptr_q] = 1'b0;
                    fetch_pc_d            = fetch_pc_q + 32'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FETCH;
            fetch_pc_q     <= RESET_PC;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            ent_instr_q[0] <= 32'd0;
            ent_instr_q[1] <= 32'd0;
            ent_pc_q[0]    <= 32'd0;
            ent_pc_q[1]    <= 32'd0;
            ent_fault_q[0] <= 1'b0;
            ent_fault_q[1] <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ent_instr_q <= ent_instr_d;
            ent_pc_q    <= ent_pc_d;
            ent_fault_q <= ent_fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        wait_instr;
    logic        instr_segv;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'd16)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_addr (instr_addr),
        .instr      (instr),
        .wait_instr (wait_instr),
        .instr_segv (instr_segv),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_fault  (out_fault)
    );

    // MMU model: word = 0xA000_0000 | addr, addresses 1..15 are invalid.
    function automatic logic [31:0] mmu_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction
    function automatic logic mmu_segv(input logic [31:0] a);
        return (a >= 32'd1) && (a <= 32'd15);
    endfunction

    assign instr      = mmu_word(instr_addr);
    assign instr_segv = mmu_segv(instr_addr);

    // Behavioural model: a queue of delivered-word records plus the fetch PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        fault;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_faulted;
    bit          chk_en = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One cycle: drive inputs at the falling edge and advance the model to the
    // state the DUT will hold after the next rising edge.
    task automatic step(input logic rst, input logic r, input logic [31:0] rpc,
                        input logic w, input logic rdy);
        bit do_pop, do_push;
        ent_t e;
        reset       = rst;
        redirect    = r;
        redirect_pc = rpc;
        wait_instr  = w;
        out_ready   = rdy;
        if (rst) begin
            m_q.delete();
            m_pc      = 32'd16;
            m_faulted = 1'b0;
        end else if (r) begin
            m_q.delete();
            m_pc      = rpc;
            m_faulted = 1'b0;
        end else begin
            do_pop  = (m_q.size() > 0) && rdy;
            do_push = !m_faulted && (m_q.size() < 2) && !w;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                e.pc = m_pc;
                if (mmu_segv(m_pc)) begin
                    e.word    = 32'd0;
                    e.fault   = 1'b1;
                    m_faulted = 1'b1;
                end else begin
                    e.word  = mmu_word(m_pc);
                    e.fault = 1'b0;
                    m_pc    = m_pc + 32'd1;
                end
                m_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic w, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, w, rdy);
    endtask

    // Single compare process against the model, between the edges.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("instr_addr", instr_addr, m_pc);
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
            if (m_q.size() > 0) begin
                chk("out_pc", out_pc, m_q[0].pc);
                chk("out_instr", out_instr, m_q[0].word);
                chk("out_fault", {31'd0, out_fault}, {31'd0, m_q[0].fault});
            end
        end
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; wait_instr = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        // Reset state pinned by literals.
        chk("rst_instr_addr", instr_addr, 32'd16);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_fault", {31'd0, out_fault}, 32'd0);

        // Streaming: pc 16, 17 on consecutive cycles.
        run(1, 1'b0, 1'b1);
        chk("stream_pc0", out_pc, 32'd16);
        chk("stream_instr0", out_instr, 32'hA000_0010);
        run(1, 1'b0, 1'b1);
        chk("stream_pc1", out_pc, 32'd17);
        run(4, 1'b0, 1'b1);

        // Backpressure from a fresh reset.
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0);
        chk("bp_instr_addr", instr_addr, 32'd18);
        chk("bp_head_pc", out_pc, 32'd16);
        run(1, 1'b0, 1'b1);
        chk("bp_rel_pc1", out_pc, 32'd17);
        run(1, 1'b0, 1'b1);
        chk("bp_rel_pc2", out_pc, 32'd18);
        run(2, 1'b0, 1'b1);

        // MMU wait at address 17.
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1);
        run(3, 1'b1, 1'b1);
        chk("wait_instr_addr", instr_addr, 32'd17);
        chk("wait_no_valid", {31'd0, out_valid}, 32'd0);
        run(1, 1'b0, 1'b1);
        chk("wait_rel_pc", out_pc, 32'd17);
        run(2, 1'b0, 1'b1);

        // Redirect into the faulting region, then out again.
        step(1'b0, 1'b1, 32'd5, 1'b0, 1'b1);
        chk("segv_redir_addr", instr_addr, 32'd5);
        run(1, 1'b0, 1'b1);
        chk("segv_fault", {31'd0, out_fault}, 32'd1);
        chk("segv_pc", out_pc, 32'd5);
        chk("segv_instr", out_instr, 32'd0);
        run(4, 1'b0, 1'b1);
        chk("segv_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("segv_hold_addr", instr_addr, 32'd5);
        step(1'b0, 1'b1, 32'd20, 1'b0, 1'b1);
        run(1, 1'b0, 1'b1);
        chk("resume_pc0", out_pc, 32'd20);
        run(1, 1'b0, 1'b1);
        chk("resume_pc1", out_pc, 32'd21);

        // Redirect with a full queue.
        run(3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'd40, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_addr", instr_addr, 32'd40);
        run(1, 1'b0, 1'b1);
        chk("flush_pc", out_pc, 32'd40);

        // Address wrap.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run(1, 1'b0, 1'b1);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFF);
        run(1, 1'b0, 1'b1);
        chk("wrap_pc1", out_pc, 32'd0);
        run(2, 1'b0, 1'b1);

        // Full and faulted, then reset.
        step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);
        chk("ff_head_pc", out_pc, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("ff_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("ff_rst_pc", out_pc, 32'd0);
        chk("ff_rst_instr", out_instr, 32'd0);
        chk("ff_rst_fault", {31'd0, out_fault}, 32'd0);
        chk("ff_rst_addr", instr_addr, 32'd16);
        run(1, 1'b0, 1'b1);
        chk("ff_rst_fetch", out_pc, 32'd16);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        rr, rs;
            logic [31:0] tgt;
            rs = ($urandom_range(0, 199) == 0);
            rr = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFFE;
                1:       tgt = 32'hFFFF_FFFF;
                default: tgt = $urandom_range(0, 40);
            endcase
            step(rs, rr, tgt, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
